// File: rtl/kf_pkg.sv
// Shared types and constants for the Kalman measurement-update front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kf_pkg;

    // One real or imaginary component, signed Q1.15.
    localparam int DW  = 16;
    // Full 2x2 complex Z matrix: eight components.
    localparam int Z_W = 8 * DW;

    // LSB offsets of each component inside a packed Z matrix, z11r in the MSBs.
    localparam int Z11R_LSB = 7 * DW;
    localparam int Z11I_LSB = 6 * DW;
    localparam int Z12R_LSB = 5 * DW;
    localparam int Z12I_LSB = 4 * DW;
    localparam int Z21R_LSB = 3 * DW;
    localparam int Z21I_LSB = 2 * DW;
    localparam int Z22R_LSB = 1 * DW;
    localparam int Z22I_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERR   = 3'd4
    } kf_seq_state_t;

endpackage

// File: rtl/kf_z_fifo.sv
// Synchronous FIFO buffering Z matrices ahead of the sequencer.
// Latency: one cycle from push to visible at dout (count/empty are registered).
// Backpressure: full blocks pushes; a pop while empty or a push while full is dropped.
// Ports: clk/rst_n, push+din write side, pop+dout read side (dout is the head, show-ahead),
//        full/empty/count derived from the registered occupancy.
module kf_z_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // DEPTH is a power of two, so the pointers wrap on their own.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read out unless count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/kf_iter_sequencer.sv
// Front-end scheduler: buffers Z matrices, issues them one at a time, captures h11.
// Latency: push into idle/empty -> kf_start 2 cycles later; kf_valid -> m_valid next edge.
// Backpressure: s_ready = !full; no issue while m_valid is held by m_ready=0 or in ERR.
// Ports: s_* Z-matrix input, kf_* pipeline interface, m_* estimate output,
//        iter_count/err_timeout/clr_err status and control, leds board indicators.
module kf_iter_sequencer #(
    parameter int DW          = kf_pkg::DW,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk_300,
    input  logic            rst_n_btn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [8*DW-1:0] s_z,
    output logic            kf_start,
    output logic            kf_init,
    output logic [8*DW-1:0] kf_z,
    input  logic            kf_valid,
    input  logic [DW-1:0]   kf_h11r,
    input  logic [DW-1:0]   kf_h11i,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [2*DW-1:0] m_h,
    output logic [15:0]     iter_count,
    output logic            err_timeout,
    input  logic            clr_err,
    output logic [3:0]      leds
);
    import kf_pkg::*;

    localparam int ZW  = 8 * DW;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    kf_seq_state_t   state_q, state_d;
    logic [ZW-1:0]   kf_z_q, kf_z_d;
    logic            kf_start_q, kf_start_d;
    logic            kf_init_q, kf_init_d;
    logic            first_q, first_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            m_valid_q, m_valid_d;
    logic [2*DW-1:0] m_h_q, m_h_d;
    logic [15:0]     iter_q, iter_d;
    logic            err_q, err_d;

    logic            fifo_pop;
    logic [ZW-1:0]   fifo_dout;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    kf_z_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ZW)
    ) u_fifo (
        .clk   (clk_300),
        .rst_n (rst_n_btn),
        .push  (s_valid && s_ready),
        .din   (s_z),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        kf_z_d     = kf_z_q;
        kf_start_d = 1'b0;
        kf_init_d  = 1'b0;
        first_d    = first_q;
        wait_cnt_d = wait_cnt_q;
        m_valid_d  = m_valid_q;
        m_h_d      = m_h_q;
        iter_d     = iter_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // An unconsumed result blocks the next issue so it is never overwritten.
                if (!fifo_empty && !m_valid_q) begin
                    fifo_pop = 1'b1;
                    kf_z_d   = fifo_dout;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                kf_start_d = 1'b1;
                kf_init_d  = first_q;
                first_d    = 1'b0;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (kf_valid) begin
                    m_h_d     = {kf_h11r, kf_h11i};
                    m_valid_d = 1'b1;
                    iter_d    = iter_q + 16'd1;
                    state_d   = ST_HOLD;
                end else if (wait_cnt_q == WCW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_HOLD: begin
                // Swallow the tail of a multi-cycle valid_all so it is captured once.
                if (!kf_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                // The pipeline state is unknown after a hang, so force a re-init.
                if (clr_err) begin
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_300 or negedge rst_n_btn) begin
        if (!rst_n_btn) begin
            state_q    <= ST_IDLE;
            kf_z_q     <= '0;
            kf_start_q <= 1'b0;
            kf_init_q  <= 1'b0;
            first_q    <= 1'b1;
            wait_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_h_q      <= '0;
            iter_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kf_z_q     <= kf_z_d;
            kf_start_q <= kf_start_d;
            kf_init_q  <= kf_init_d;
            first_q    <= first_d;
            wait_cnt_q <= wait_cnt_d;
            m_valid_q  <= m_valid_d;
            m_h_q      <= m_h_d;
            iter_q     <= iter_d;
            err_q      <= err_d;
        end
    end

    assign s_ready     = !fifo_full;
    assign kf_start    = kf_start_q;
    assign kf_init     = kf_init_q;
    assign kf_z        = kf_z_q;
    assign m_valid     = m_valid_q;
    assign m_h         = m_h_q;
    assign iter_count  = iter_q;
    assign err_timeout = err_q;
    assign leds        = {fifo_count == CW'(FIFO_DEPTH), err_q, state_q != ST_IDLE, m_valid_q};

endmodule

// File: tb/tb_kf_iter_sequencer.sv
// Bench for kf_iter_sequencer: transaction model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_kf_iter_sequencer;
    import kf_pkg::*;

    localparam int DEPTH = 4;
    localparam int TO    = 1024;

    logic            clk_300   = 1'b0;
    logic            rst_n_btn = 1'b0;
    logic            s_valid   = 1'b0;
    logic [Z_W-1:0]  s_z       = '0;
    logic            kf_valid  = 1'b0;
    logic [DW-1:0]   kf_h11r   = '0;
    logic [DW-1:0]   kf_h11i   = '0;
    logic            m_ready   = 1'b0;
    logic            clr_err   = 1'b0;
    logic            s_ready, kf_start, kf_init, m_valid, err_timeout;
    logic [Z_W-1:0]  kf_z;
    logic [2*DW-1:0] m_h;
    logic [15:0]     iter_count;
    logic [3:0]      leds;

    always #5 clk_300 = ~clk_300;

    kf_iter_sequencer #(.DW(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk_300(clk_300), .rst_n_btn(rst_n_btn), .s_valid(s_valid), .s_ready(s_ready),
        .s_z(s_z), .kf_start(kf_start), .kf_init(kf_init), .kf_z(kf_z),
        .kf_valid(kf_valid), .kf_h11r(kf_h11r), .kf_h11i(kf_h11i),
        .m_valid(m_valid), .m_ready(m_ready), .m_h(m_h), .iter_count(iter_count),
        .err_timeout(err_timeout), .clr_err(clr_err), .leds(leds)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [Z_W-1:0] act, input logic [Z_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [Z_W-1:0] mkz(input logic [DW-1:0] r, input logic [DW-1:0] i);
        logic [Z_W-1:0] z;
        z = '0;
        z[Z11R_LSB +: DW] = r;
        z[Z11I_LSB +: DW] = i;
        z[Z22I_LSB +: DW] = r ^ i;   // makes the low component distinctive too
        return z;
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [Z_W-1:0]  zq[$];
    logic [Z_W-1:0]  md_z     = '0;
    bit              md_busy  = 0;  // matrix popped, no result/timeout yet
    bit              md_hold  = 0;  // result taken, waiting for valid_all to drop
    bit              md_err   = 0;
    bit              md_first = 1;
    bit              md_mv    = 0;
    bit              md_start = 0;
    bit              md_init  = 0;
    bit              md_push, md_pop;
    logic [2*DW-1:0] md_mh    = '0;
    logic [15:0]     md_iter  = '0;
    int              md_t     = 0;  // edges since the pop

    always begin
        @(posedge clk_300 or negedge rst_n_btn);
        if (!rst_n_btn) begin
            zq.delete();
            md_z = '0; md_busy = 0; md_hold = 0; md_err = 0; md_first = 1; md_mv = 0;
            md_start = 0; md_init = 0; md_mh = '0; md_iter = '0; md_t = 0;
        end else begin
            md_push  = s_valid && (zq.size() < DEPTH);
            md_pop   = !md_busy && !md_hold && !md_err && !md_mv && (zq.size() != 0);
            md_start = 0;
            md_init  = 0;
            if (md_mv && m_ready) md_mv = 0;
            if (md_err) begin
                if (clr_err) begin md_err = 0; md_first = 1; end
            end else if (md_hold) begin
                if (!kf_valid) md_hold = 0;
            end else if (md_busy) begin
                md_t++;
                if (md_t == 1) begin
                    md_start = 1; md_init = md_first; md_first = 0;
                end else if (kf_valid) begin
                    md_mh = {kf_h11r, kf_h11i}; md_mv = 1; md_iter++;
                    md_busy = 0; md_hold = 1;
                end else if (md_t == TO + 1) begin
                    md_err = 1; md_busy = 0;
                end
            end
            if (md_pop) begin md_z = zq.pop_front(); md_busy = 1; md_t = 0; end
            if (md_push) zq.push_back(s_z);
        end
    end

    always begin
        @(negedge clk_300);
        chk("m_s_ready", s_ready, zq.size() < DEPTH);
        chk("m_kf_start", kf_start, md_start);
        chk("m_kf_init", kf_init, md_init);
        chk("m_kf_z", kf_z, md_z);
        chk("m_m_valid", m_valid, md_mv);
        chk("m_m_h", m_h, md_mh);
        chk("m_iter", iter_count, md_iter);
        chk("m_err", err_timeout, md_err);
        chk("m_leds", leds, {zq.size() == DEPTH, md_err, md_busy || md_hold || md_err, md_mv});
    end

    // ---------------- pipeline stand-in: h11 = z11 / 2 ----------------
    int             pipe_lat  = 10;
    int             pipe_len  = 1;
    bit             pipe_dead = 0;
    logic [Z_W-1:0] pz;

    initial begin
        forever begin
            @(negedge clk_300);
            if (kf_start && !pipe_dead) begin
                pz = kf_z;
                repeat (pipe_lat) @(negedge clk_300);
                kf_h11r  = $signed(pz[Z11R_LSB +: DW]) >>> 1;
                kf_h11i  = $signed(pz[Z11I_LSB +: DW]) >>> 1;
                kf_valid = 1'b1;
                repeat (pipe_len) @(negedge clk_300);
                kf_valid = 1'b0;
            end
        end
    end

    int start_cnt = 0;
    int init_cnt  = 0;
    always begin
        @(negedge clk_300);
        if (kf_start) start_cnt++;
        if (kf_init)  init_cnt++;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic push(input logic [Z_W-1:0] z);
        s_valid = 1'b1;
        s_z     = z;
        @(negedge clk_300);
        s_valid = 1'b0;
    endtask

    task automatic wait_for(input int sel, input logic [15:0] tgt, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3000; i++) begin
            case (sel)
                0:       hit = kf_start;
                1:       hit = m_valid;
                2:       hit = (iter_count == tgt);
                default: hit = err_timeout;
            endcase
            if (hit) break;
            @(negedge clk_300);
        end
        n_vec++;
        if (!hit) begin
            n_miss++;
            $display("FAIL %s: got 0 required 1 within 3000 cycles", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_kf_start"}, kf_start, 1'b0);
        chk({tag, "_kf_init"}, kf_init, 1'b0);
        chk({tag, "_kf_z"}, kf_z, '0);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_h"}, m_h, '0);
        chk({tag, "_iter"}, iter_count, 16'd0);
        chk({tag, "_err"}, err_timeout, 1'b0);
        chk({tag, "_leds"}, leds, 4'b0000);
    endtask

    task automatic do_reset();
        #2 rst_n_btn = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk_300);
        @(negedge clk_300);
        #2 rst_n_btn = 1'b1;
        @(negedge clk_300);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench watchdog expired");
    end

    int n, s0;
    logic [15:0] i0;

    initial begin
        // Reset state
        @(negedge clk_300);
        check_reset_outputs("por");
        #2 rst_n_btn = 1'b1;
        @(negedge clk_300);

        // T1: single iteration with exact latency
        m_ready = 1'b0;
        push(mkz(16'd26214, -16'sd3277));
        chk("t1_lat0", kf_start, 1'b0);
        @(negedge clk_300);
        chk("t1_lat1", kf_start, 1'b0);
        @(negedge clk_300);
        chk("t1_start", kf_start, 1'b1);
        chk("t1_init", kf_init, 1'b1);
        @(negedge clk_300);
        chk("t1_start_1cyc", kf_start, 1'b0);
        chk("t1_init_1cyc", kf_init, 1'b0);
        wait_for(1, 0, "t1_m_valid");
        chk("t1_m_h", m_h, 32'h3333_F999);
        chk("t1_iter", iter_count, 16'd1);
        m_ready = 1'b1;
        @(negedge clk_300);
        @(negedge clk_300);
        chk("t1_m_valid_fall", m_valid, 1'b0);

        // T2: back-to-back; one matrix is in flight so four more fill the FIFO
        do_reset();
        start_cnt = 0; init_cnt = 0;
        push(mkz(16'd7, 16'd9));
        wait_for(0, 0, "t2_first_start");
        for (int k = 1; k <= 4; k++) push(mkz(16'(k * 1000), 16'(-k)));
        chk("t2_full_s_ready", s_ready, 1'b0);
        chk("t2_full_led", leds[3], 1'b1);
        wait_for(2, 16'd5, "t2_iter5");
        chk("t2_starts", start_cnt, 5);
        chk("t2_inits", init_cnt, 1);

        // T3: backpressure holds the result and blocks the next issue
        @(negedge clk_300);
        m_ready = 1'b0;
        push(mkz(16'd1000, -16'sd2000));
        push(mkz(16'd3000, 16'd4000));
        wait_for(1, 0, "t3_m_valid");
        s0 = start_cnt;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_300);
            chk("t3_m_h_stable", m_h, 32'h01F4_FC18);
        end
        chk("t3_no_issue", start_cnt, s0);
        m_ready = 1'b1;
        wait_for(0, 0, "t3_second_start");
        wait_for(2, 16'd7, "t3_iter7");

        // T4: five-cycle valid_all captured once; next issue waits for it to drop
        @(negedge clk_300);
        pipe_len = 5;
        i0 = iter_count;
        push(mkz(16'd200, 16'd300));
        push(mkz(16'd400, 16'd500));
        wait_for(1, 0, "t4_m_valid");
        n = 0;
        while (!kf_start && n < 20) begin @(negedge clk_300); n++; end
        chk("t4_next_start_gap", n, 7);
        chk("t4_iter_once", iter_count, i0 + 16'd1);
        wait_for(2, i0 + 16'd2, "t4_iter_second");
        pipe_len = 1;
        @(negedge clk_300);

        // T5: hang detection, ERR keeps buffering, clr_err forces re-init
        pipe_dead = 1;
        push(mkz(16'd11, 16'd12));
        wait_for(0, 0, "t5_start");
        n = 0;
        while (!err_timeout && n < TO + 100) begin @(negedge clk_300); n++; end
        chk("t5_timeout_cycles", n, TO);
        chk("t5_led_err", leds[2], 1'b1);
        push(mkz(16'd13, 16'd14));
        push(mkz(16'd15, 16'd16));
        s0 = start_cnt;
        repeat (20) @(negedge clk_300);
        chk("t5_no_issue_in_err", start_cnt, s0);
        pipe_dead = 0;
        clr_err = 1'b1;
        @(negedge clk_300);
        clr_err = 1'b0;
        wait_for(0, 0, "t5_restart");
        chk("t5_reinit", kf_init, 1'b1);

        // T6: reset while waiting with two entries queued
        wait_for(0, 0, "t6_pre_start");
        @(negedge clk_300);
        while (kf_start) @(negedge clk_300);
        wait_for(0, 0, "t6_start");
        push(mkz(16'd21, 16'd22));
        push(mkz(16'd23, 16'd24));
        do_reset();
        s0 = start_cnt;
        repeat (30) @(negedge clk_300);
        chk("t6_no_reissue", start_cnt, s0);
        chk("t6_iter", iter_count, 16'd0);
        push(mkz(16'd31, 16'd32));
        wait_for(0, 0, "t6_new_start");
        chk("t6_new_init", kf_init, 1'b1);
        chk("t6_new_z", kf_z, mkz(16'd31, 16'd32));
        repeat (20) @(negedge clk_300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
